// File: rtl/periodic_rst_seq_if.sv
// Control/status bundle for periodic_rst_seq.
// The slave modport is the sequencer side, the master modport is the controller side.
interface periodic_rst_seq_if #(
  parameter int unsigned N_CH = 2
) ();
  logic            enable_in;
  logic            mode_in;
  logic            trig_in;
  logic [N_CH-1:0] rst_out;
  logic            busy_out;
  logic [15:0]     cycle_cnt_out;

  modport master (
    output enable_in,
    output mode_in,
    output trig_in,
    input  rst_out,
    input  busy_out,
    input  cycle_cnt_out
  );

  modport slave (
    input  enable_in,
    input  mode_in,
    input  trig_in,
    output rst_out,
    output busy_out,
    output cycle_cnt_out
  );
endinterface

// File: rtl/periodic_rst_seq.sv
// Periodic reset sequencer: drives N_CH active-high resets with a programmable period,
// on-time and per-channel release stagger, timed by a free-running prescaler tick.
// Build option: define RSTSEQ_STAGGER_EN for staggered channel release; without it all
// channels release together when the count reaches ON_TIME.
module periodic_rst_seq #(
  parameter int unsigned PRESCALE = 100,
  parameter int unsigned PERIOD   = 10000000,
  parameter int unsigned ON_TIME  = 1000000,
  parameter int unsigned N_CH     = 2,
  parameter int unsigned STAGGER  = 16,
  parameter int unsigned CNT_W    = 30
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  periodic_rst_seq_if.slave  bus_io
);

  localparam int unsigned PrescW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
`ifdef RSTSEQ_STAGGER_EN
  localparam int unsigned StaggerEff = STAGGER;
`else
  localparam int unsigned StaggerEff = 0;
`endif
  localparam logic [PrescW-1:0] PrescLast = PrescW'(PRESCALE - 1);
  localparam logic [CNT_W-1:0]  OnTimeC   = CNT_W'(ON_TIME);
  localparam logic [CNT_W-1:0]  RelEndC   = CNT_W'(ON_TIME + (N_CH - 1) * StaggerEff);
  localparam logic [CNT_W-1:0]  PeriodM1  = CNT_W'(PERIOD - 1);

  typedef enum logic [1:0] {StIdle, StAssert, StRelease, StRun} state_e;

  state_e             state_q, state_d;
  logic [PrescW-1:0]  presc_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [N_CH-1:0]    rst_q, rst_d;
  logic               busy_q, busy_d;
  logic [15:0]        cycle_q, cycle_d;
  logic               tick;

  // Count at which channel ch leaves reset.
  function automatic logic [CNT_W-1:0] rel_thr(input int unsigned ch);
    return CNT_W'(ON_TIME + ch * StaggerEff);
  endfunction

  assign tick    = (presc_q == PrescLast);
  assign cnt_inc = cnt_q + CNT_W'(1);

  // Free-running prescaler; never restarted by a trigger.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PrescW'(1);
    end
  end

  // Sequencer next state, tick counter and registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cycle_d = cycle_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.trig_in || (bus_io.enable_in && !bus_io.mode_in)) begin
          state_d = StAssert;
          cnt_d   = '0;
        end
      end
      StAssert, StRelease: begin
        if (tick) begin
          cnt_d = cnt_inc;
          // Completion is checked first so an unstaggered build skips RELEASE entirely.
          if (cnt_inc == RelEndC) begin
            cycle_d = cycle_q + 16'd1;
            state_d = (bus_io.enable_in && !bus_io.mode_in) ? StRun : StIdle;
          end else if (cnt_inc == OnTimeC) begin
            state_d = StRelease;
          end
        end
      end
      StRun: begin
        if (bus_io.trig_in) begin
          state_d = StAssert;
          cnt_d   = '0;
        end else if (!bus_io.enable_in) begin
          state_d = StIdle;
        end else if (tick) begin
          if (cnt_q == PeriodM1) begin
            state_d = StAssert;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StAssert) || (state_d == StRelease);
    for (int unsigned i = 0; i < N_CH; i++) begin
      rst_d[i] = busy_d && (cnt_d < rel_thr(i));
    end
  end

  // State and output registers; reset starts a full power-up sequence.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= StAssert;
      cnt_q   <= '0;
      rst_q   <= '1;
      busy_q  <= 1'b1;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      busy_q  <= busy_d;
      cycle_q <= cycle_d;
    end
  end

  assign bus_io.rst_out       = rst_q;
  assign bus_io.busy_out      = busy_q;
  assign bus_io.cycle_cnt_out = cycle_q;

endmodule

// File: tb/tb_periodic_rst_seq.sv
// Scoreboard bench for periodic_rst_seq: a timeline model (ticks since the last sequence
// start) predicts outputs every clock; a monitor compares them on the falling edge.
module tb_periodic_rst_seq;

  localparam int P   = 4;
  localparam int PER = 20;
  localparam int ON  = 3;
  localparam int N   = 3;
  localparam int ST  = 2;
`ifdef RSTSEQ_STAGGER_EN
  localparam int ST_EFF = ST;
`else
  localparam int ST_EFF = 0;
`endif
  localparam int REL  = ON + (N - 1) * ST_EFF;
  localparam int MID  = (ST_EFF > 0) ? ON + ST_EFF : 1;
  localparam int DROP = (REL > 4) ? 4 : 1;

  typedef struct {
    logic [N-1:0] rst;
    logic         busy;
    logic [15:0]  cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q[$];

  // Model state: sequence in flight, periodic timeline alive, ticks since start.
  int m_busy = 1, m_alive = 0, m_since = 0, m_cycles = 0, m_nclk = 0;

  periodic_rst_seq_if #(.N_CH(N)) bus_if ();

  periodic_rst_seq #(
    .PRESCALE(P), .PERIOD(PER), .ON_TIME(ON), .N_CH(N), .STAGGER(ST), .CNT_W(30)
  ) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus_io  (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    for (int i = 0; i < N; i++) e.rst[i] = (m_busy != 0) && (m_since < ON + i * ST_EFF);
    e.busy = (m_busy != 0);
    e.cyc  = 16'(m_cycles);
    return e;
  endfunction

  task automatic model_reset();
    m_busy = 1; m_alive = 0; m_since = 0; m_cycles = 0; m_nclk = 0;
  endtask

  task automatic model_step();
    bit tick, start;
    tick  = (m_nclk % P) == P - 1;
    start = 0;
    m_nclk++;
    if (m_busy != 0) begin
      if (tick) begin
        m_since++;
        if (m_since == REL) begin
          m_busy   = 0;
          m_cycles = (m_cycles + 1) % 65536;
          m_alive  = int'(bus_if.enable_in && !bus_if.mode_in);
        end
      end
    end else if (bus_if.trig_in) begin
      start = 1;
    end else if (m_alive != 0) begin
      if (!bus_if.enable_in) m_alive = 0;
      else if (tick) begin
        if (m_since == PER - 1) start = 1;
        else m_since++;
      end
    end else if (bus_if.enable_in && !bus_if.mode_in) begin
      start = 1;
    end
    if (start) begin
      m_busy  = 1;
      m_since = 0;
    end
  endtask

  // Asynchronous reset: outputs are forced at once, so stale predictions are dropped.
  always @(negedge rst_n) begin
    model_reset();
    q.delete();
    q.push_back(model_out());
  end

  always @(posedge clk) begin
    if (rst_n) model_step();
    else model_reset();
    q.push_back(model_out());
  end

  // Monitor: one prediction consumed per clock.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
    end else begin
      e = q.pop_front();
      check("rst_out", 32'(bus_if.rst_out), 32'(e.rst));
      check("busy_out", 32'(bus_if.busy_out), 32'(e.busy));
      check("cycle_cnt_out", 32'(bus_if.cycle_cnt_out), 32'(e.cyc));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic async_reset(input string name, input int hold);
    rst_n = 1'b0;
    #1;
    check({name, "_rst_out"}, 32'(bus_if.rst_out), 32'((1 << N) - 1));
    check({name, "_busy_out"}, 32'(bus_if.busy_out), 32'd1);
    check({name, "_cycle_cnt_out"}, 32'(bus_if.cycle_cnt_out), 32'd0);
    step(hold);
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises;
    int k;
    logic [N-1:0] prev;
    bus_if.enable_in = 1'b0;
    bus_if.mode_in   = 1'b0;
    bus_if.trig_in   = 1'b0;

    // Power-up sequence with enable low, ends in IDLE with one completed sequence.
    step(3);
    rst_n = 1'b1;
    step(40);
    check("powerup_cycle_cnt", 32'(bus_if.cycle_cnt_out), 32'd1);
    check("powerup_idle_busy", 32'(bus_if.busy_out), 32'd0);

    // Periodic mode.
    bus_if.enable_in = 1'b1;
    step(300);

    // One-shot mode with manual trigger; second trigger lands during RELEASE.
    bus_if.enable_in = 1'b0;
    step(100);
    bus_if.mode_in   = 1'b1;
    bus_if.enable_in = 1'b1;
    bus_if.trig_in   = 1'b1;
    step(1);
    bus_if.trig_in   = 1'b0;
    check("trig_latency_rst_out", 32'(bus_if.rst_out), 32'((1 << N) - 1));
    step(18);
    bus_if.trig_in = 1'b1;
    step(1);
    bus_if.trig_in = 1'b0;
    step(60);

    // Enable dropped mid-sequence: the sequence completes, then no further pulses.
    bus_if.mode_in = 1'b0;
    k = 0;
    do begin
      step(1);
      k++;
    end while (!(m_busy != 0 && m_since == DROP) && k < 400);
    check("wait_drop_point", 32'(k < 400), 32'd1);
    bus_if.enable_in = 1'b0;
    step(50);
    rises = 0;
    prev  = bus_if.rst_out;
    for (int c = 0; c < 200; c++) begin
      step(1);
      if ((bus_if.rst_out & ~prev) != '0) rises++;
      prev = bus_if.rst_out;
    end
    check("no_pulse_after_disable", 32'(rises), 32'd0);

    // Reset asserted mid-release.
    bus_if.enable_in = 1'b1;
    step(90);
    k = 0;
    do begin
      step(1);
      k++;
    end while (!(m_busy != 0 && m_since >= MID) && k < 400);
    check("wait_mid_release", 32'(k < 400), 32'd1);
    async_reset("midseq", 2);
    step(40);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      bus_if.trig_in = ($urandom_range(39) == 0);
      if ($urandom_range(59) == 0) bus_if.enable_in = ~bus_if.enable_in;
      if ($urandom_range(79) == 0) bus_if.mode_in = ~bus_if.mode_in;
      if ($urandom_range(499) == 0) async_reset("rand", int'($urandom_range(3, 1)));
      else step(1);
    end
    bus_if.trig_in = 1'b0;
    step(4);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
